// File: rtl/dp_data_mem.sv
// True dual-port data memory with byte-lane writes, write-first cross-port
// reads, dual-write collision flag and a hardware clear sweep.
module dp_data_mem #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 14,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_en,
    input  logic [DATA_W/8-1:0] a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_din,
    output logic [DATA_W-1:0]   a_dout,
    output logic                a_valid,
    input  logic                b_en,
    input  logic [DATA_W/8-1:0] b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_din,
    output logic [DATA_W-1:0]   b_dout,
    output logic                b_valid,
    input  logic                clear_req,
    output logic                busy,
    output logic                collision
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    localparam state_t RST_ST = (INIT_CLEAR != 0) ? S_CLEAR : S_READY;

    generate
        if ((DATA_W % 8) != 0) begin : g_bad_w
            $error("dp_data_mem: DATA_W must be a multiple of 8");
        end
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("dp_data_mem: RD_LAT must be 1 or 2");
        end
    endgenerate

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_ST;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_CLEAR: begin
                cnt_n = cnt + ADDR_W'(1);
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_n = S_READY;
                end
            end
            S_READY: begin
                if (clear_req) begin
                    state_n = S_CLEAR;
                    cnt_n   = '0;
                end
            end
        endcase
    end

    assign busy  = (state == S_CLEAR);
    assign ready = ~busy;

    logic a_wr, a_rd, b_wr, b_rd, same_addr;

    assign a_wr      = ready & a_en & (|a_we);
    assign a_rd      = ready & a_en & ~(|a_we);
    assign b_wr      = ready & b_en & (|b_we);
    assign b_rd      = ready & b_en & ~(|b_we);
    assign same_addr = (a_addr == b_addr);

    logic [DATA_W-1:0] mem [DEPTH];

    // Port A lanes are written last so A wins overlapping lanes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr && b_we[i]) begin
                    mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (a_wr && a_we[i]) begin
                    mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] a_rword, b_rword;

    // Write-first: a reader sees the other port's same-cycle write lanes.
    always_comb begin
        a_rword = mem[a_addr];
        for (int i = 0; i < NB; i++) begin
            if (b_wr && same_addr && b_we[i]) begin
                a_rword[8*i +: 8] = b_din[8*i +: 8];
            end
        end
    end

    always_comb begin
        b_rword = mem[b_addr];
        for (int i = 0; i < NB; i++) begin
            if (a_wr && same_addr && a_we[i]) begin
                b_rword[8*i +: 8] = a_din[8*i +: 8];
            end
        end
    end

    logic [DATA_W-1:0] a_q1, b_q1;
    logic              a_v1, b_v1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q1      <= '0;
            b_q1      <= '0;
            a_v1      <= 1'b0;
            b_v1      <= 1'b0;
            collision <= 1'b0;
        end else begin
            a_v1      <= a_rd;
            b_v1      <= b_rd;
            collision <= a_wr & b_wr & same_addr & (|(a_we & b_we));
            if (a_rd) begin
                a_q1 <= a_rword;
            end
            if (b_rd) begin
                b_q1 <= b_rword;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] a_q2, b_q2;
            logic              a_v2, b_v2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q2 <= '0;
                    b_q2 <= '0;
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                end else begin
                    a_v2 <= a_v1;
                    b_v2 <= b_v1;
                    if (a_v1) begin
                        a_q2 <= a_q1;
                    end
                    if (b_v1) begin
                        b_q2 <= b_q1;
                    end
                end
            end

            assign a_dout  = a_q2;
            assign a_valid = a_v2;
            assign b_dout  = b_q2;
            assign b_valid = b_v2;
        end else begin : g_lat1
            assign a_dout  = a_q1;
            assign a_valid = a_v1;
            assign b_dout  = b_q1;
            assign b_valid = b_v1;
        end
    endgenerate

endmodule

// File: tb/tb_dp_data_mem.sv
// Bench for dp_data_mem: directed and random dual-port traffic on RD_LAT=1
// and RD_LAT=2 instances, compared against an array-based reference.
module tb_dp_data_mem;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_en, b_en, clear_req;
    logic [7:0]    a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;

    logic [DW-1:0] d1_a_dout, d1_b_dout, d2_a_dout, d2_b_dout;
    logic          d1_a_valid, d1_b_valid, d2_a_valid, d2_b_valid;
    logic          d1_busy, d2_busy, d1_coll, d2_coll;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dp_data_mem #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .INIT_CLEAR(1)) d1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(d1_a_dout), .a_valid(d1_a_valid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(d1_b_dout), .b_valid(d1_b_valid),
        .clear_req(clear_req), .busy(d1_busy), .collision(d1_coll)
    );

    dp_data_mem #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .INIT_CLEAR(1)) d2 (
        .clk(clk), .rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(d2_a_dout), .a_valid(d2_a_valid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(d2_b_dout), .b_valid(d2_b_valid),
        .clear_req(clear_req), .busy(d2_busy), .collision(d2_coll)
    );

    // Reference state: array contents, cycles of sweep left, read pipeline.
    logic [DW-1:0] m_mem [DEPTH];
    int            busy_left;
    logic          m_coll;
    logic          s1a_v, s1b_v, s2a_v, s2b_v;
    logic [DW-1:0] s1a_d, s1b_d, s2a_d, s2b_d;
    logic [DW-1:0] h1a, h1b, h2a, h2b;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [7:0] we,
                                            input logic [DW-1:0] din);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (we[i]) r[8*i +: 8] = din[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        busy_left = DEPTH;
        m_coll = 1'b0;
        s1a_v = 1'b0; s1b_v = 1'b0; s2a_v = 1'b0; s2b_v = 1'b0;
        s1a_d = '0; s1b_d = '0; s2a_d = '0; s2b_d = '0;
        h1a = '0; h1b = '0; h2a = '0; h2b = '0;
    endtask

    task automatic check_all();
        chk("busy1", 64'(d1_busy), 64'(busy_left != 0));
        chk("busy2", 64'(d2_busy), 64'(busy_left != 0));
        chk("coll1", 64'(d1_coll), 64'(m_coll));
        chk("coll2", 64'(d2_coll), 64'(m_coll));
        chk("a_valid1", 64'(d1_a_valid), 64'(s1a_v));
        chk("b_valid1", 64'(d1_b_valid), 64'(s1b_v));
        chk("a_valid2", 64'(d2_a_valid), 64'(s2a_v));
        chk("b_valid2", 64'(d2_b_valid), 64'(s2b_v));
        chk("a_dout1", d1_a_dout, h1a);
        chk("b_dout1", d1_b_dout, h1b);
        chk("a_dout2", d2_a_dout, h2a);
        chk("b_dout2", d2_b_dout, h2b);
    endtask

    task automatic step(input logic ae, input logic [7:0] awe,
                        input logic [AW-1:0] aad, input logic [DW-1:0] adi,
                        input logic be, input logic [7:0] bwe,
                        input logic [AW-1:0] bad, input logic [DW-1:0] bdi,
                        input logic clr);
        logic rdy, aw, bw, ra, rb;
        logic [DW-1:0] rad, rbd;
        a_en = ae; a_we = awe; a_addr = aad; a_din = adi;
        b_en = be; b_we = bwe; b_addr = bad; b_din = bdi;
        clear_req = clr;
        rdy = (busy_left == 0);
        aw  = rdy && ae && (awe != 0);
        bw  = rdy && be && (bwe != 0);
        ra  = rdy && ae && (awe == 0);
        rb  = rdy && be && (bwe == 0);
        rad = m_mem[aad];
        if (bw && bad == aad) rad = merge(rad, bwe, bdi);
        rbd = m_mem[bad];
        if (aw && aad == bad) rbd = merge(rbd, awe, adi);
        m_coll = aw && bw && (aad == bad) && ((awe & bwe) != 0);
        if (rdy) begin
            if (bw) m_mem[bad] = merge(m_mem[bad], bwe, bdi);
            if (aw) m_mem[aad] = merge(m_mem[aad], awe, adi);
            if (clr) busy_left = DEPTH;
        end else begin
            m_mem[DEPTH - busy_left] = '0;
            busy_left--;
        end
        s2a_v = s1a_v; s2a_d = s1a_d; s2b_v = s1b_v; s2b_d = s1b_d;
        s1a_v = ra; s1a_d = rad; s1b_v = rb; s1b_d = rbd;
        if (s1a_v) h1a = s1a_d;
        if (s1b_v) h1b = s1b_d;
        if (s2a_v) h2a = s2a_d;
        if (s2b_v) h2b = s2b_d;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_a(input logic [AW-1:0] ad, input logic [7:0] we,
                        input logic [DW-1:0] d);
        step(1, we, ad, d, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_ab(input logic [AW-1:0] ad);
        step(1, 0, ad, 0, 1, 0, ad, 0, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_a_dout1", d1_a_dout, 0);
        chk("rst_b_dout1", d1_b_dout, 0);
        chk("rst_a_dout2", d2_a_dout, 0);
        chk("rst_b_dout2", d2_b_dout, 0);
        chk("rst_valid", 64'({d1_a_valid, d1_b_valid, d2_a_valid, d2_b_valid}), 0);
        chk("rst_busy", 64'({d1_busy, d2_busy}), 64'h3);
        chk("rst_coll", 64'({d1_coll, d2_coll}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        a_en = 0; a_we = 0; a_addr = 0; a_din = 0;
        b_en = 0; b_we = 0; b_addr = 0; b_din = 0;
        clear_req = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();

        // Power-up sweep, then every word reads zero on A.
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 4'(i), 0, 0, 0, 0, 0, 0);
        idle(2);

        // Full write then lane-0 overwrite of addr 3.
        wr_a(3, 8'hFF, 64'h1122334455667788);
        wr_a(3, 8'h01, 64'hAA);
        step(0, 0, 0, 0, 1, 0, 3, 0, 0);
        chk("b3_lat1", d1_b_dout, 64'h11223344556677AA);
        chk("b3_v2_early", 64'(d2_b_valid), 0);
        idle(1);
        chk("b3_lat2", d2_b_dout, 64'h11223344556677AA);

        // Write-first cross-port read.
        step(1, 8'h0F, 5, '1, 1, 0, 5, 0, 0);
        chk("wf_b5", d1_b_dout, 64'h00000000FFFFFFFF);
        chk("wf_coll", 64'(d1_coll), 0);
        idle(1);

        // Dual write with overlapping lane, then non-overlapping.
        step(1, 8'h03, 7, '1, 1, 8'h06, 7, 0, 0);
        chk("dw_coll", 64'(d1_coll), 1);
        rd_ab(7);
        chk("dw_m7", d1_a_dout, 64'h000000000000FFFF);
        step(1, 8'h01, 8, '1, 1, 8'h02, 8, 0, 0);
        chk("dw_nocoll", 64'(d1_coll), 0);
        idle(2);

        // Requested clear with a dropped write during the sweep.
        wr_a(2, 8'hFF, 64'hDEADBEEFCAFEF00D);
        wr_a(10, 8'hFF, 64'h0123456789ABCDEF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(9);
        wr_a(2, 8'hFF, 64'h5555AAAA5555AAAA);
        idle(DEPTH - 10);
        for (int i = 0; i < DEPTH; i++) rd_ab(4'(i));
        idle(2);

        // Reset mid-sweep restarts the full sweep.
        wr_a(9, 8'hFF, 64'hFEEDFACE12345678);
        rd_ab(9);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(6);
        reset_pulse();
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd_ab(4'(i));

        // Random traffic on a few addresses to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00,
                 4'($urandom_range(0, 3)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00,
                 4'($urandom_range(0, 3)), {$urandom, $urandom},
                 ($urandom_range(0, 39) == 0));
        end
        idle(DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
